// File: rtl/ad7908_spi_model.sv
// SPI responder emulating an AD7908 8-channel 8-bit ADC: decodes the 12-bit control
// word on DIN and returns {0, ADD[2:0], DATA[7:0], 0000} frames on DOUT.
module ad7908_spi_model #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] RESET_ADDR  = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_din,
    output logic        spi_dout,
    input  logic [63:0] ch_data,
    output logic [11:0] ctrl_reg,
    output logic [2:0]  cur_addr,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_din_sync;
    logic                   r_cs_d, r_sclk_d;
    logic [SYNC_STAGES:0]   r_vld;

    state_t      r_state, w_state_next;
    logic [15:0] r_tx_sr, w_tx_sr_next;
    logic [15:0] r_rx_sr, w_rx_sr_next;
    logic [4:0]  r_bit_cnt, w_bit_cnt_next;
    logic        r_armed, w_armed_next;
    logic        r_dout, w_dout_next;
    logic [11:0] r_ctrl, w_ctrl_next;
    logic [2:0]  r_addr, w_addr_next;
    logic        r_done, w_done_next;
    logic        r_err, w_err_next;

    logic       w_valid, w_cs, w_sclk, w_din;
    logic       w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
    logic [7:0] w_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '1;
            r_din_sync  <= '0;
            r_cs_d      <= 1'b1;
            r_sclk_d    <= 1'b1;
            r_vld       <= '0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], spi_din};
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_vld       <= {r_vld[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are only trusted once the reset values have flushed out of the
    // chains, otherwise a CS held low through reset would look like a fall.
    assign w_valid     = r_vld[SYNC_STAGES];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_din       = r_din_sync[SYNC_STAGES-1];
    assign w_cs_fall   = w_valid & r_cs_d & ~w_cs;
    assign w_cs_rise   = w_valid & ~r_cs_d & w_cs;
    assign w_sclk_rise = w_valid & ~r_sclk_d & w_sclk;
    assign w_sclk_fall = w_valid & r_sclk_d & ~w_sclk;
    assign w_sample    = ch_data[8*r_addr +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
            r_armed   <= 1'b0;
            r_dout    <= 1'b0;
            r_ctrl    <= '0;
            r_addr    <= RESET_ADDR;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tx_sr   <= w_tx_sr_next;
            r_rx_sr   <= w_rx_sr_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_armed   <= w_armed_next;
            r_dout    <= w_dout_next;
            r_ctrl    <= w_ctrl_next;
            r_addr    <= w_addr_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_tx_sr_next   = r_tx_sr;
        w_rx_sr_next   = r_rx_sr;
        w_bit_cnt_next = r_bit_cnt;
        w_armed_next   = r_armed;
        w_dout_next    = r_dout;
        w_ctrl_next    = r_ctrl;
        w_addr_next    = r_addr;
        w_done_next    = 1'b0;
        w_err_next     = 1'b0;
        case (r_state)
            IDLE: begin
                w_dout_next = 1'b0;
                if (w_valid && w_cs)
                    w_armed_next = 1'b1;
                if (w_cs_fall && r_armed) begin
                    w_tx_sr_next   = {1'b0, r_addr, w_sample, 4'b0000};
                    w_rx_sr_next   = '0;
                    w_bit_cnt_next = '0;
                    w_state_next   = ACTIVE;
                end
            end
            ACTIVE: begin
                // CS has priority: a coincident SCLK edge is dropped.
                if (w_cs_rise) begin
                    w_dout_next  = 1'b0;
                    w_state_next = IDLE;
                    if (r_bit_cnt == 5'd16) begin
                        w_done_next = 1'b1;
                        if (r_rx_sr[15]) begin
                            w_ctrl_next = r_rx_sr[15:4];
                            w_addr_next = r_rx_sr[12:10];
                        end
                    end else begin
                        w_err_next = 1'b1;
                    end
                end else if (w_sclk_rise) begin
                    if (r_bit_cnt < 5'd16) begin
                        w_rx_sr_next   = {r_rx_sr[14:0], w_din};
                        w_bit_cnt_next = r_bit_cnt + 5'd1;
                    end
                end else if (w_sclk_fall) begin
                    if (r_bit_cnt == 5'd16) begin
                        w_dout_next = 1'b0;
                    end else if (r_bit_cnt != 5'd0) begin
                        w_tx_sr_next = {r_tx_sr[14:0], 1'b0};
                        w_dout_next  = r_tx_sr[14];
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign spi_dout   = r_dout;
    assign ctrl_reg   = r_ctrl;
    assign cur_addr   = r_addr;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_ad7908_spi_model.sv
// Directed bench for ad7908_spi_model: bit-bangs SPI frames and checks DOUT frames,
// control-word capture, error pulses, mid-frame reset and alternating channel reads.
module tb_ad7908_spi_model;

    localparam int HALF = 8;  // SCLK half-period in clk cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sclk = 1'b1;
    logic        spi_din = 1'b0;
    logic        spi_dout;
    logic [63:0] ch_data;
    logic [11:0] ctrl_reg;
    logic [2:0]  cur_addr;
    logic        frame_done;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    ad7908_spi_model #(.SYNC_STAGES(2), .RESET_ADDR(3'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_din    (spi_din),
        .spi_dout   (spi_dout),
        .ch_data    (ch_data),
        .ctrl_reg   (ctrl_reg),
        .cur_addr   (cur_addr),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // hook_kind 1: ch0 <= 8'h11 before bit hook_bit; 2: pulse rst_n before bit hook_bit
    task automatic frame(input logic [15:0] w, input int nrise, input int hook_bit,
                         input int hook_kind, output logic [15:0] rd);
        rd = '0;
        spi_cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nrise; i++) begin
            if (i == hook_bit && hook_kind == 1) ch_data[7:0] = 8'h11;
            if (i == hook_bit && hook_kind == 2) begin
                rst_n = 1'b0;
                wait_clk(3);
                rst_n = 1'b1;
            end
            spi_sclk = 1'b0;
            spi_din  = w[15-i];
            wait_clk(HALF);
            rd[15-i] = spi_dout;
            spi_sclk = 1'b1;
            wait_clk(HALF);
        end
        spi_cs_n = 1'b1;
        wait_clk(2*HALF);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rd;
        int          d0, e0;
        logic [2:0]  exp_addr;
        logic [11:0] word;

        ch_data = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h3C, 8'hA5};
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(10);

        chk("rst_dout", spi_dout, 0);
        chk("rst_ctrl", ctrl_reg, 12'h000);
        chk("rst_addr", cur_addr, 3'd0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", frame_err, 0);

        d0 = done_cnt;
        frame({12'h831, 4'h0}, 16, -1, 0, rd);
        chk("f1_dout", rd, 16'h0A50);
        chk("f1_done", done_cnt - d0, 1);
        chk("f1_ctrl", ctrl_reg, 12'h831);
        chk("f1_addr", cur_addr, 3'd0);
        chk("f1_idle_dout", spi_dout, 0);

        frame({12'h871, 4'h0}, 16, -1, 0, rd);
        chk("f2_dout", rd, 16'h0A50);
        chk("f2_ctrl", ctrl_reg, 12'h871);
        chk("f2_addr", cur_addr, 3'd1);

        frame({12'h831, 4'h0}, 16, -1, 0, rd);
        chk("f3_dout", rd, 16'h13C0);
        chk("f3_addr", cur_addr, 3'd0);

        frame({12'h071, 4'h0}, 16, -1, 0, rd);
        chk("f4_dout", rd, 16'h0A50);
        chk("f4_ctrl", ctrl_reg, 12'h831);
        chk("f4_addr", cur_addr, 3'd0);

        frame({12'h831, 4'h0}, 16, -1, 0, rd);
        chk("f5_dout", rd, 16'h0A50);

        d0 = done_cnt;
        e0 = err_cnt;
        frame({12'h871, 4'h0}, 8, -1, 0, rd);
        chk("f6_err", err_cnt - e0, 1);
        chk("f6_done", done_cnt - d0, 0);
        chk("f6_addr", cur_addr, 3'd0);
        chk("f6_ctrl", ctrl_reg, 12'h831);
        chk("f6_dout", spi_dout, 0);

        d0 = done_cnt;
        frame({12'h831, 4'h0}, 16, -1, 0, rd);
        chk("f7_dout", rd, 16'h0A50);
        chk("f7_done", done_cnt - d0, 1);

        frame({12'h831, 4'h0}, 16, 6, 1, rd);
        chk("f8_dout", rd, 16'h0A50);
        frame({12'h831, 4'h0}, 16, -1, 0, rd);
        chk("f9_dout", rd, 16'h0110);
        ch_data[7:0] = 8'hA5;

        // Move cur_addr to 1 so the mid-frame reset visibly restores it.
        frame({12'h871, 4'h0}, 16, -1, 0, rd);
        chk("f10_addr", cur_addr, 3'd1);
        d0 = done_cnt;
        e0 = err_cnt;
        frame({12'h871, 4'h0}, 16, 9, 2, rd);
        chk("rstmid_tail", {16'h0, rd & 16'h007F}, 0);
        chk("rstmid_done", done_cnt - d0, 0);
        chk("rstmid_err", err_cnt - e0, 0);
        chk("rstmid_ctrl", ctrl_reg, 12'h000);
        chk("rstmid_addr", cur_addr, 3'd0);
        chk("rstmid_dout", spi_dout, 0);

        d0 = done_cnt;
        frame({12'h871, 4'h0}, 16, -1, 0, rd);
        chk("f11_dout", rd, 16'h0A50);
        chk("f11_done", done_cnt - d0, 1);
        chk("f11_addr", cur_addr, 3'd1);

        exp_addr = 3'd1;
        for (int f = 0; f < 100; f++) begin
            word = (f % 2 == 0) ? 12'h831 : 12'h871;
            frame({word, 4'h0}, 16, -1, 0, rd);
            chk(exp_addr == 3'd0 ? "loop_dial" : "loop_cds", rd,
                exp_addr == 3'd0 ? 16'h0A50 : 16'h13C0);
            exp_addr = word[8:6];
        end
        chk("loop_addr", cur_addr, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
